barrel_shift_arbiter: RTL and testbench
=======================================

BARREL_SHIFT_ARBITER -- requirements
Module: barrel_shift_arbiter

Interface
REQ-001 Parameter AMT_W, default 5: width of the requested shift amount (0..2^AMT_W-1).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-006 req0_data / req1_data  input  8  operand to be shifted.
REQ-007 req0_amt / req1_amt  input  AMT_W  total left-shift amount.
REQ-008 req0_ready / req1_ready  output  1  request accepted this cycle when valid&ready.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_data  output  8  shifted result.
REQ-011 resp_id  output  1  index of the requester that owns resp_data.
REQ-012 resp_ready  input  1  consumer accepts result when resp_valid&resp_ready.
REQ-013 sh_x  output  8  operand to the shared external 8-bit shifter.
REQ-014 sh_amt  output  3  shift amount to the shared shifter.
REQ-015 sh_out  input  8  combinational shifter result, sh_x << sh_amt with zero fill.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-017 In IDLE, when exactly one valid is high, that requester SHALL be granted; when both are high, the requester not granted last SHALL win (round-robin).
REQ-018 In IDLE, ready SHALL be driven combinationally high only for the granted requester; in SHIFT and DONE, both readys SHALL be 0.
REQ-019 On acceptance the block SHALL latch work=data, rem=amt and id, and update the round-robin pointer to the granted index.
REQ-020 On acceptance with amt=0 the FSM SHALL go to DONE; otherwise it SHALL go to SHIFT.
REQ-021 In SHIFT, each cycle: sh_x=work and step=min(rem,7) SHALL be driven to sh_amt; work SHALL load sh_out; rem SHALL load rem-step.
REQ-022 The FSM SHALL leave SHIFT for DONE in the cycle where rem-step=0.
REQ-023 Outside SHIFT, sh_x SHALL equal work and sh_amt SHALL be 0.
REQ-024 Pass count SHALL be ceil(amt/7); resp_valid SHALL rise 1+passes cycles after the acceptance edge (1 cycle for amt=0).
REQ-025 In DONE, resp_valid=1 and resp_data=work and resp_id=id SHALL hold stable until resp_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-026 No new request SHALL be granted in the cycle the response is consumed; arbitration resumes in the following IDLE cycle.
REQ-027 Request inputs changing while not accepted SHALL not affect the operation in flight.
REQ-028 Amounts of 8 or more SHALL still be executed as multiple passes, yielding 0x00 for any operand.

Reset
REQ-029 While rst_n=0: state=IDLE, resp_valid=0, resp_data=0x00, resp_id=0, work=0, rem=0, both readys 0, and the round-robin pointer set so req0 wins the first tie.
REQ-030 Reset asserted mid-operation SHALL discard the operation without producing a response; the requester SHALL re-issue it.

Verification
REQ-031 Scenario 1: req0 x=0x81, amt=3 -> one pass, sh_amt=3, resp_data=0x08, resp_id=0, resp_valid 2 cycles after acceptance.
REQ-032 Scenario 2: req1 x=0x01, amt=7 -> 0x80 in 1 pass; x=0x01, amt=9 -> passes 7 then 2, result 0x00, resp_valid 3 cycles after acceptance.
REQ-033 Scenario 3: amt=0, x=0x5A -> resp_data=0x5A, 1 cycle after acceptance, and sh_amt stays 0.
REQ-034 Scenario 4: both valids held high for four operations -> grant order req0, req1, req0, req1.
REQ-035 Scenario 5: resp_ready held low 3 cycles in DONE -> resp_valid/data/id stable, both readys 0; release -> IDLE next cycle.
REQ-036 Scenario 6: rst_n pulsed low during SHIFT of amt=20 -> no response, all outputs at reset values, next tie granted to req0.

Source files
------------

// File: rtl/barrel_shift_arbiter.sv
// Two-requester round-robin front end for a shared 8-bit shifter.
// Shift amounts larger than 7 are split into passes of at most 7 bits each.
module barrel_shift_arbiter #(
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    output logic             req1_ready,
    output logic             resp_valid,
    output logic [7:0]       resp_data,
    output logic             resp_id,
    input  logic             resp_ready,
    output logic [7:0]       sh_x,
    output logic [2:0]       sh_amt,
    input  logic [7:0]       sh_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       work_q, work_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             id_q, id_d;
    logic             last_q, last_d;

    logic             grantValid;
    logic             grantIdx;
    logic [7:0]       grantData;
    logic [AMT_W-1:0] grantAmt;
    logic [AMT_W-1:0] step;
    logic [AMT_W-1:0] remNext;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grantValid = (state_q == IDLE) && (req0_valid || req1_valid);
        grantIdx   = 1'b0;
        if (req0_valid && req1_valid) begin
            grantIdx = ~last_q;
        end else if (req1_valid) begin
            grantIdx = 1'b1;
        end
        grantData = grantIdx ? req1_data : req0_data;
        grantAmt  = grantIdx ? req1_amt  : req0_amt;
    end

    assign req0_ready = rst_n && grantValid && !grantIdx;
    assign req1_ready = rst_n && grantValid &&  grantIdx;

    assign step    = (rem_q > AMT_W'(7)) ? AMT_W'(7) : rem_q;
    assign remNext = rem_q - step;

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        rem_d      = rem_q;
        id_d       = id_q;
        last_d     = last_q;
        sh_x       = work_q;
        sh_amt     = 3'd0;
        resp_valid = 1'b0;
        resp_data  = 8'h00;
        resp_id    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grantValid) begin
                    work_d  = grantData;
                    rem_d   = grantAmt;
                    id_d    = grantIdx;
                    last_d  = grantIdx;
                    state_d = (grantAmt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                sh_amt = step[2:0];
                work_d = sh_out;
                rem_d  = remNext;
                if (remNext == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_data  = work_q;
                resp_id    = id_q;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // last_q resets to 1 so that req0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= 8'h00;
            rem_q   <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed, table-driven bench for barrel_shift_arbiter with a behavioural
// model of the external shifter.
module tb_barrel_shift_arbiter;

    localparam int AMT_W = 5;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic [7:0]       req0_data, req1_data;
    logic [AMT_W-1:0] req0_amt, req1_amt;
    logic             req0_ready, req1_ready;
    logic             resp_valid;
    logic [7:0]       resp_data;
    logic             resp_id;
    logic             resp_ready;
    logic [7:0]       sh_x;
    logic [2:0]       sh_amt;
    logic [7:0]       sh_out;

    int checks = 0;
    int errors = 0;

    barrel_shift_arbiter #(.AMT_W(AMT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_ready (req1_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_ready (resp_ready),
        .sh_x       (sh_x),
        .sh_amt     (sh_amt),
        .sh_out     (sh_out)
    );

    // External shifter: zero-fill left shift, truncated to 8 bits.
    assign sh_out = sh_x << sh_amt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic       v1;
        logic [7:0] d0;
        logic [4:0] a0;
        logic [7:0] d1;
        logic [4:0] a1;
        logic       expId;
        logic [7:0] expData;
        int         expLat;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mkVec(logic v0, logic v1, logic [7:0] d0, logic [4:0] a0,
                                   logic [7:0] d1, logic [4:0] a1, logic expId,
                                   logic [7:0] expData, int expLat);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.d0 = d0; v.a0 = a0; v.d1 = d1; v.a1 = a1;
        v.expId = expId; v.expData = expData; v.expLat = expLat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] d0, input logic [4:0] a0,
                                 input logic v1, input logic [7:0] d1, input logic [4:0] a1);
        req0_valid = v0; req0_data = d0; req0_amt = a0;
        req1_valid = v1; req1_data = d1; req1_amt = a1;
    endtask

    // Called #1 after the acceptance edge; latency counts the acceptance cycle as 0.
    task automatic waitResp(output int lat, output bit readyLeak);
        lat = 1;
        readyLeak = 1'b0;
        while (!resp_valid && lat < 60) begin
            if (req0_ready || req1_ready) readyLeak = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) checkOutput("respTimeout", 0, 1);
    endtask

    task automatic consume();
        @(negedge clk);
        resp_ready = 1'b1;
        #1;
        checkOutput("readyInConsume", {30'd0, req1_ready, req0_ready}, 0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput("validAfterConsume", int'(resp_valid), 0);
    endtask

    initial begin
        int  lat;
        bit  leak;
        logic [7:0] heldData;
        logic       heldId;
        logic       expGrant;
        int  waitCnt;

        rst_n = 1'b0;
        resp_ready = 1'b0;
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 5'd0);

        vecs[0] = mkVec(1, 0, 8'h81, 5'd3,  8'h00, 5'd0,  0, 8'h08, 2);
        vecs[1] = mkVec(0, 1, 8'h00, 5'd0,  8'h01, 5'd7,  1, 8'h80, 2);
        vecs[2] = mkVec(0, 1, 8'h00, 5'd0,  8'h01, 5'd9,  1, 8'h00, 3);
        vecs[3] = mkVec(1, 0, 8'h5A, 5'd0,  8'h00, 5'd0,  0, 8'h5A, 1);
        vecs[4] = mkVec(1, 1, 8'hF0, 5'd1,  8'h33, 5'd2,  1, 8'hCC, 2);
        vecs[5] = mkVec(1, 1, 8'hF0, 5'd1,  8'h33, 5'd2,  0, 8'hE0, 2);
        vecs[6] = mkVec(1, 0, 8'hFF, 5'd14, 8'h00, 5'd0,  0, 8'h00, 3);
        vecs[7] = mkVec(0, 1, 8'h00, 5'd0,  8'h03, 5'd31, 1, 8'h00, 6);
        vecs[8] = mkVec(1, 0, 8'hC3, 5'd4,  8'h00, 5'd0,  0, 8'h30, 2);
        vecs[9] = mkVec(0, 1, 8'h00, 5'd0,  8'h01, 5'd6,  1, 8'h40, 2);

        repeat (2) @(negedge clk);
        checkOutput("rstRespValid", int'(resp_valid), 0);
        checkOutput("rstRespData", int'(resp_data), 0);
        checkOutput("rstRespId", int'(resp_id), 0);
        checkOutput("rstReadys", {30'd0, req1_ready, req0_ready}, 0);
        checkOutput("rstShX", int'(sh_x), 0);
        checkOutput("rstShAmt", int'(sh_amt), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].v0, vecs[i].d0, vecs[i].a0, vecs[i].v1, vecs[i].d1, vecs[i].a1);
            #1;
            checkOutput($sformatf("v%0d ready", i), {30'd0, req1_ready, req0_ready},
                        vecs[i].expId ? 2 : 1);
            @(posedge clk); #1;
            applyStimulus(1'b0, 8'hA5, 5'd17, 1'b0, 8'h3C, 5'd11);
            waitResp(lat, leak);
            checkOutput($sformatf("v%0d latency", i), lat, vecs[i].expLat);
            checkOutput($sformatf("v%0d data", i), int'(resp_data), int'(vecs[i].expData));
            checkOutput($sformatf("v%0d id", i), int'(resp_id), int'(vecs[i].expId));
            checkOutput($sformatf("v%0d busyReady", i), int'(leak), 0);
            consume();
        end

        // Two-pass shift: passes of 7 then 2 on the shared shifter.
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b1, 8'h01, 5'd9);
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 5'd0);
        checkOutput("s2 pass1 amt", int'(sh_amt), 7);
        checkOutput("s2 pass1 x", int'(sh_x), 8'h01);
        @(posedge clk); #1;
        checkOutput("s2 pass2 amt", int'(sh_amt), 2);
        checkOutput("s2 pass2 x", int'(sh_x), 8'h80);
        @(posedge clk); #1;
        checkOutput("s2 done valid", int'(resp_valid), 1);
        checkOutput("s2 done data", int'(resp_data), 0);
        checkOutput("s2 done shAmt", int'(sh_amt), 0);
        consume();

        // Zero amount never touches the shifter.
        @(negedge clk);
        applyStimulus(1'b1, 8'h5A, 5'd0, 1'b0, 8'h00, 5'd0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 5'd0);
        checkOutput("s3 valid", int'(resp_valid), 1);
        checkOutput("s3 shAmt", int'(sh_amt), 0);
        checkOutput("s3 data", int'(resp_data), 8'h5A);
        consume();

        // Back-pressure: response held stable while new requests wait.
        @(negedge clk);
        applyStimulus(1'b1, 8'h81, 5'd3, 1'b0, 8'h00, 5'd0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'hFF, 5'd1, 1'b1, 8'hEE, 5'd2);
        waitResp(lat, leak);
        heldData = resp_data;
        heldId = resp_id;
        checkOutput("s5 data", int'(heldData), 8'h08);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("s5 hold%0d valid", k), int'(resp_valid), 1);
            checkOutput($sformatf("s5 hold%0d data", k), int'(resp_data), int'(heldData));
            checkOutput($sformatf("s5 hold%0d id", k), int'(resp_id), int'(heldId));
            checkOutput($sformatf("s5 hold%0d readys", k), {30'd0, req1_ready, req0_ready}, 0);
        end
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 5'd0);
        consume();

        // Reset during a long shift discards it and restores req0 tie priority.
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b1, 8'hFF, 5'd20);
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 5'd0);
        checkOutput("s6 shifting", int'(sh_amt), 7);
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(1'b1, 8'h11, 5'd1, 1'b1, 8'h22, 5'd1);
        #1;
        checkOutput("s6 rstValid", int'(resp_valid), 0);
        checkOutput("s6 rstData", int'(resp_data), 0);
        checkOutput("s6 rstId", int'(resp_id), 0);
        checkOutput("s6 rstReadys", {30'd0, req1_ready, req0_ready}, 0);
        checkOutput("s6 rstShX", int'(sh_x), 0);
        checkOutput("s6 rstShAmt", int'(sh_amt), 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("s6 noResp", int'(resp_valid), 0);
        rst_n = 1'b1;

        // Both requesters held high: grants must alternate starting with req0.
        expGrant = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            checkOutput($sformatf("s4 op%0d grant", k), {30'd0, req1_ready, req0_ready},
                        expGrant ? 2 : 1);
            @(posedge clk); #1;
            waitCnt = 0;
            waitResp(lat, leak);
            checkOutput($sformatf("s4 op%0d id", k), int'(resp_id), int'(expGrant));
            checkOutput($sformatf("s4 op%0d data", k), int'(resp_data), expGrant ? 8'h44 : 8'h22);
            consume();
            expGrant = ~expGrant;
        end
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 5'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
